// File: rtl/bitmap_rmw_pkg.sv
// Shared definitions for the bitmap read-modify-write controller: op encodings,
// init sequencer state type and a small op-classification helper.
package bitmap_rmw_pkg;

    localparam int unsigned OP_WIDTH = 2;

    typedef enum logic [OP_WIDTH-1:0] {
        OP_READ  = 2'b00,
        OP_SET   = 2'b01,
        OP_CLR   = 2'b10,
        OP_WRITE = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        StIdle,
        StClear,
        StRun
    } init_state_e;

    // Every op except READ commits a new word to the RAM.
    function automatic logic is_write_op(input op_e op);
        return op != OP_READ;
    endfunction

endpackage

// File: rtl/bitmap_rmw_init_seq.sv
// Clear sequencer: after reset walks every RAM word writing zero, then reports done.
// Only instantiated when BITMAP_RMW_INIT_CLEAR_EN is defined.
module bitmap_rmw_init_seq
    import bitmap_rmw_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr,
    output logic                  done
);

    init_state_e           state_q, state_d;
    // One extra bit so the carry out of the last address marks completion.
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;

    // State and counter registers; reset restarts the sweep from address 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic and clear-write outputs.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        clr_we   = 1'b0;
        clr_addr = cnt_q[ADDR_WIDTH-1:0];
        done     = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d   = '0;
                state_d = StClear;
            end
            StClear: begin
                clr_we = ~rst;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_d[ADDR_WIDTH]) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                done = 1'b1;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule

// File: rtl/bitmap_rmw_ctrl.sv
// Pipelined read-modify-write controller for the 1W2R allocation-bitmap RAM.
// Port 1 feeds the RMW pipeline (accept -> S1 modify/write), port 2 a read-only query channel.
// A one-entry forward register hides the RAM's stale same-edge read.
// Optional: define BITMAP_RMW_INIT_CLEAR_EN to zero the RAM after reset before accepting work.
module bitmap_rmw_ctrl
    import bitmap_rmw_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [OP_WIDTH-1:0]   req_op,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_mask,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    input  logic                  qry_en,
    input  logic [ADDR_WIDTH-1:0] qry_addr,
    output logic                  qry_valid,
    output logic [DATA_WIDTH-1:0] qry_data,
    output logic                  init_done,
    output logic                  ram_write_en,
    output logic [ADDR_WIDTH-1:0] ram_write_addr,
    output logic [DATA_WIDTH-1:0] ram_write_data,
    output logic [ADDR_WIDTH-1:0] ram_read_addr1,
    input  logic [DATA_WIDTH-1:0] ram_read_data1,
    output logic [ADDR_WIDTH-1:0] ram_read_addr2,
    input  logic [DATA_WIDTH-1:0] ram_read_data2
);

    logic                  accept;
    logic                  qry_accept;

    logic                  s1_v_q;
    op_e                   s1_op_q;
    logic [ADDR_WIDTH-1:0] s1_addr_q;
    logic [DATA_WIDTH-1:0] s1_mask_q;

    logic                  fwd_v_q;
    logic [ADDR_WIDTH-1:0] fwd_addr_q;
    logic [DATA_WIDTH-1:0] fwd_data_q;

    logic                  qry_v_q;
    logic                  qry_hit_q;
    logic [DATA_WIDTH-1:0] qry_fwd_q;

    logic [DATA_WIDTH-1:0] old_word;
    logic [DATA_WIDTH-1:0] new_word;
    logic                  s1_wr;

`ifdef BITMAP_RMW_INIT_CLEAR_EN
    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;

    bitmap_rmw_init_seq #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_init_seq (
        .clk      (clk),
        .rst      (rst),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .done     (init_done)
    );
`else
    logic init_q;

    // Without the clear sweep the RAM is usable the cycle after reset releases.
    always_ff @(posedge clk) begin
        if (rst) begin
            init_q <= 1'b0;
        end else begin
            init_q <= 1'b1;
        end
    end

    assign init_done = init_q;
`endif

    assign req_ready      = init_done & ~rst;
    assign accept         = req_valid & req_ready;
    assign qry_accept     = qry_en & init_done & ~rst;
    assign ram_read_addr1 = req_addr;
    assign ram_read_addr2 = qry_addr;

    // S1 datapath: pick the freshest old word, apply the op, drive response.
    always_comb begin
        old_word = ram_read_data1;
        if (fwd_v_q && (fwd_addr_q == s1_addr_q)) begin
            old_word = fwd_data_q;
        end
        new_word = old_word;
        unique case (s1_op_q)
            OP_READ:  new_word = old_word;
            OP_SET:   new_word = old_word | s1_mask_q;
            OP_CLR:   new_word = old_word & ~s1_mask_q;
            OP_WRITE: new_word = s1_mask_q;
            default:  new_word = old_word;
        endcase
        // Reset in the S1 cycle drops the op entirely.
        s1_wr     = s1_v_q & ~rst & is_write_op(s1_op_q);
        rsp_valid = s1_v_q & ~rst;
        rsp_data  = old_word;
    end

    // RAM write port: the clear sweep and S1 never coexist since no request is accepted mid-sweep.
    always_comb begin
        ram_write_en   = s1_wr;
        ram_write_addr = s1_addr_q;
        ram_write_data = new_word;
`ifdef BITMAP_RMW_INIT_CLEAR_EN
        if (clr_we) begin
            ram_write_en   = 1'b1;
            ram_write_addr = clr_addr;
            ram_write_data = '0;
        end
`endif
    end

    // S1 stage capture of the accepted request.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q <= 1'b0;
        end else begin
            s1_v_q <= accept;
        end
        if (accept) begin
            s1_op_q   <= op_e'(req_op);
            s1_addr_q <= req_addr;
            s1_mask_q <= req_mask;
        end
    end

    // Forward register holds the word written last cycle, which the RAM read misses.
    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_v_q <= 1'b0;
        end else begin
            fwd_v_q <= s1_wr;
        end
        fwd_addr_q <= s1_addr_q;
        fwd_data_q <= new_word;
    end

    // Query pipeline: remember whether the S1 write on the query cycle hit the queried word.
    always_ff @(posedge clk) begin
        if (rst) begin
            qry_v_q   <= 1'b0;
            qry_hit_q <= 1'b0;
        end else begin
            qry_v_q   <= qry_accept;
            qry_hit_q <= s1_wr && (s1_addr_q == qry_addr);
        end
        qry_fwd_q <= new_word;
    end

    assign qry_valid = qry_v_q & ~rst;
    assign qry_data  = qry_hit_q ? qry_fwd_q : ram_read_data2;

endmodule

// File: tb/tb_bitmap_rmw_ctrl.sv
// Self-checking bench for bitmap_rmw_ctrl: a registered 1W2R RAM model, a sequential
// reference memory that applies each accepted op in order, a per-cycle compare process
// and directed tests with hand-computed expectations.
module tb_bitmap_rmw_ctrl;
    import bitmap_rmw_pkg::*;

    localparam int unsigned AW    = 6;
    localparam int unsigned DW    = 64;
    localparam int unsigned DEPTH = 1 << AW;
`ifdef BITMAP_RMW_INIT_CLEAR_EN
    localparam int INIT_CYC = DEPTH + 1;
`else
    localparam int INIT_CYC = 1;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [1:0]    req_op = 2'b00;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_mask = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          qry_en = 1'b0;
    logic [AW-1:0] qry_addr = '0;
    logic          qry_valid;
    logic [DW-1:0] qry_data;
    logic          init_done;
    logic          ram_write_en;
    logic [AW-1:0] ram_write_addr;
    logic [DW-1:0] ram_write_data;
    logic [AW-1:0] ram_read_addr1;
    logic [DW-1:0] ram_read_data1;
    logic [AW-1:0] ram_read_addr2;
    logic [DW-1:0] ram_read_data2;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    bitmap_rmw_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op         (req_op),
        .req_addr       (req_addr),
        .req_mask       (req_mask),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .qry_en         (qry_en),
        .qry_addr       (qry_addr),
        .qry_valid      (qry_valid),
        .qry_data       (qry_data),
        .init_done      (init_done),
        .ram_write_en   (ram_write_en),
        .ram_write_addr (ram_write_addr),
        .ram_write_data (ram_write_data),
        .ram_read_addr1 (ram_read_addr1),
        .ram_read_data1 (ram_read_data1),
        .ram_read_addr2 (ram_read_addr2),
        .ram_read_data2 (ram_read_data2)
    );

    // Registered 1W2R RAM: a same-edge read returns the old word.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_write_en) mem[ram_write_addr] <= ram_write_data;
        ram_read_data1 <= mem[ram_read_addr1];
        ram_read_data2 <= mem[ram_read_addr2];
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: ops take effect in acceptance order; a query sees every op
    // accepted before its own cycle; reset undoes the op still waiting in the pipe.
    logic [DW-1:0] ref_mem   [DEPTH];
    bit            ref_known [DEPTH];
    bit            init_m     = 0;
    int            init_cnt   = 0;
    bit            exp_rsp_v  = 0;
    logic [DW-1:0] exp_rsp_d  = '0;
    bit            exp_rsp_k  = 0;
    bit            exp_qry_v  = 0;
    logic [DW-1:0] exp_qry_d  = '0;
    bit            exp_qry_k  = 0;
    bit            pend_v     = 0;
    logic [AW-1:0] pend_addr  = '0;
    logic [DW-1:0] pend_old   = '0;
    bit            pend_known = 0;

    always @(posedge clk) begin
        if (rst) begin
            if (pend_v) begin
                ref_mem[pend_addr]   = pend_old;
                ref_known[pend_addr] = pend_known;
            end
            pend_v    = 0;
            exp_rsp_v = 0;
            exp_qry_v = 0;
            init_m    = 0;
            init_cnt  = 0;
        end else begin
            exp_qry_v = qry_en && init_m;
            exp_qry_d = ref_mem[qry_addr];
            exp_qry_k = ref_known[qry_addr];
            exp_rsp_v = req_valid && init_m;
            pend_v    = exp_rsp_v;
            if (exp_rsp_v) begin
                exp_rsp_d  = ref_mem[req_addr];
                exp_rsp_k  = ref_known[req_addr];
                pend_addr  = req_addr;
                pend_old   = exp_rsp_d;
                pend_known = exp_rsp_k;
                case (req_op)
                    2'b01: ref_mem[req_addr] = exp_rsp_d | req_mask;
                    2'b10: ref_mem[req_addr] = exp_rsp_d & ~req_mask;
                    2'b11: begin
                        ref_mem[req_addr]   = req_mask;
                        ref_known[req_addr] = 1;
                    end
                    default: ;
                endcase
            end
            if (!init_m) begin
                init_cnt++;
                if (init_cnt == INIT_CYC) begin
                    init_m = 1;
`ifdef BITMAP_RMW_INIT_CLEAR_EN
                    for (int i = 0; i < int'(DEPTH); i++) begin
                        ref_mem[i]   = '0;
                        ref_known[i] = 1;
                    end
`endif
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("req_ready", DW'(req_ready), DW'(init_m && !rst));
        chk("rsp_valid", DW'(rsp_valid), DW'(exp_rsp_v && !rst));
        if (rsp_valid && exp_rsp_v && exp_rsp_k && !rst) chk("rsp_data", rsp_data, exp_rsp_d);
        chk("qry_valid", DW'(qry_valid), DW'(exp_qry_v && !rst));
        if (qry_valid && exp_qry_v && exp_qry_k && !rst) chk("qry_data", qry_data, exp_qry_d);
        if (rst) chk("no_write_in_rst", DW'(ram_write_en), '0);
    end

    task automatic step(input logic r, input logic v, input logic [1:0] op, input logic [AW-1:0] a,
                        input logic [DW-1:0] m, input logic qe, input logic [AW-1:0] qa);
        @(posedge clk);
        #1;
        rst = r; req_valid = v; req_op = op; req_addr = a; req_mask = m;
        qry_en = qe; qry_addr = qa;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, OP_READ, '0, '0, 1'b0, '0);
    endtask

    task automatic req(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] m);
        step(1'b0, 1'b1, op, a, m, 1'b0, '0);
    endtask

    // Counts cycles from the first non-reset cycle until init_done rises (bounded).
    task automatic wait_init(output int n);
        n = 0;
        forever begin
            @(negedge clk);
            if (init_done || n >= 200) break;
            idle();
            n++;
        end
    endtask

    function automatic logic [AW-1:0] hot_addr(input int k);
        case (k)
            0: return 6'd3;
            1: return 6'd5;
            2: return 6'd7;
            default: return 6'd40;
        endcase
    endfunction

    initial begin
        int n;
        // Reset state
        step(1'b1, 1'b0, OP_READ, '0, '0, 1'b0, '0);
        step(1'b1, 1'b0, OP_READ, '0, '0, 1'b0, '0);
        @(negedge clk);
        chk("rst_req_ready", DW'(req_ready), '0);
        chk("rst_rsp_valid", DW'(rsp_valid), '0);
        chk("rst_qry_valid", DW'(qry_valid), '0);
        idle();
        wait_init(n);
        chk("init_latency", DW'(n), DW'(INIT_CYC));
        chk("init_done", DW'(init_done), 64'd1);
`ifdef BITMAP_RMW_INIT_CLEAR_EN
        step(1'b0, 1'b0, OP_READ, '0, '0, 1'b1, 6'd63);
        idle();
        @(negedge clk);
        chk("clear_a63", qry_data, 64'h0);
`endif
        // WRITE then READ back-to-back
        req(OP_WRITE, 6'd5, 64'hFF00);
        req(OP_READ, 6'd5, '0);
        @(negedge clk);
        chk("t2_rsp1_valid", DW'(rsp_valid), 64'd1);
        idle();
        @(negedge clk);
        chk("t2_rsp2_valid", DW'(rsp_valid), 64'd1);
        chk("t2_read", rsp_data, 64'hFF00);
        // Same-address chain
        req(OP_WRITE, 6'd3, 64'h0);
        req(OP_SET, 6'd3, 64'h1);
        req(OP_SET, 6'd3, 64'h2);
        @(negedge clk);
        chk("t3_set1_old", rsp_data, 64'h0);
        req(OP_CLR, 6'd3, 64'h1);
        @(negedge clk);
        chk("t3_set2_old", rsp_data, 64'h1);
        req(OP_READ, 6'd3, '0);
        @(negedge clk);
        chk("t3_clr_old", rsp_data, 64'h3);
        idle();
        @(negedge clk);
        chk("t3_final", rsp_data, 64'h2);
        // Query vs S1 commit on the same word
        req(OP_SET, 6'd3, 64'h4);
        step(1'b0, 1'b0, OP_READ, '0, '0, 1'b1, 6'd3);
        @(negedge clk);
        chk("t4_set_old", rsp_data, 64'h2);
        step(1'b0, 1'b1, OP_CLR, 6'd3, 64'h4, 1'b1, 6'd3);
        @(negedge clk);
        chk("t4_qry_fwd", qry_data, 64'h6);
        step(1'b0, 1'b0, OP_READ, '0, '0, 1'b1, 6'd3);
        @(negedge clk);
        chk("t4_qry_not_same_cycle", qry_data, 64'h6);
        idle();
        @(negedge clk);
        chk("t4_qry_after_clr", qry_data, 64'h2);
        // Reset drops an in-flight WRITE
        req(OP_WRITE, 6'd7, 64'h1234);
        idle();
        req(OP_WRITE, 6'd7, 64'hBEEF);
        step(1'b1, 1'b0, OP_READ, '0, '0, 1'b0, '0);
        @(negedge clk);
        chk("t5_write_en", DW'(ram_write_en), '0);
        chk("t5_rsp_valid", DW'(rsp_valid), '0);
        idle();
        wait_init(n);
        chk("t5_reinit", DW'(n), DW'(INIT_CYC));
        req(OP_READ, 6'd7, '0);
        idle();
        @(negedge clk);
        chk("t5_unchanged", rsp_data, 64'h1234);
        // Random hot-address stream, checked by the model every cycle
        req(OP_WRITE, 6'd40, 64'h0);
        for (int i = 0; i < 10000; i++) begin
            step(1'b0, $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                 hot_addr($urandom_range(0, 3)), {$urandom, $urandom},
                 1'($urandom_range(0, 1)), hot_addr($urandom_range(0, 3)));
        end
        idle();
        idle();
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
